mips_debug_ctrl: RTL and testbench

Parametrised run/step/breakpoint controller and debug display for the MIPS SoC on the FPGA board. It replaces the derived slow clock with a single-cycle clock-enable (cpu_ce) that is generated on the board clock. It adds a programmable divider, a debounced single-step button, a PC breakpoint and an N-channel LED display mux. It sits between the board pins and mips_soc, which runs on clk and is gated by cpu_ce.

---
 rtl/mips_debug_ctrl.sv | 147 ++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// Run/step/breakpoint controller for the MIPS SoC: issues a single-cycle cpu_ce
// on the board clock, debounces the step button and muxes debug channels onto the LEDs.
module mips_debug_ctrl #(
    parameter int DATA_W          = 32,
    parameter int NUM_CH          = 4,
    parameter int LED_W           = 16,
    parameter int DIV_W           = 26,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_sw,
    input  logic                       step_btn,
    input  logic [4:0]                 div_sel,
    input  logic                       bp_en,
    input  logic [DATA_W-1:0]          bp_addr,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
    input  logic                       half_sel,
    output logic                       cpu_ce,
    output logic                       halted,
    output logic [1:0]                 state,
    output logic [15:0]                step_count,
    output logic [LED_W-1:0]           led
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_PAUSE = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    logic            sync_p0, sync_p1;
    logic            deb_level, deb_prev;
    logic [DB_W-1:0] deb_cnt;
    logic            step_req;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_mask;
    logic [4:0]       sel_eff;
    logic             tick;
    logic             bp_hit;

    logic [1:0]       state_nxt;
    logic [LED_W-1:0] led_nxt;

    // Stage p0/p1: metastability synchroniser, then debounce on the p1 level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_p0  <= step_btn;
            sync_p1  <= sync_p0;
            deb_prev <= deb_level;
            if (sync_p1 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_LAST) begin
                deb_level <= sync_p1;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step_req = deb_level & ~deb_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= div_cnt + 1'b1;
    end

    always_comb begin
        sel_eff = (int'(div_sel) >= DIV_W) ? 5'(DIV_W - 1) : div_sel;
        for (int i = 0; i < DIV_W; i++) begin
            div_mask[i] = (i < int'(sel_eff));
        end
    end

    assign tick   = ((div_cnt & div_mask) == div_mask);
    assign bp_hit = bp_en && (pc_in == bp_addr);

    // cpu_ce stays combinational so the breakpoint can suppress the very tick that matches
    always_comb begin
        state_nxt = state;
        cpu_ce    = 1'b0;
        case (state)
            S_PAUSE: begin
                if (run_sw)        state_nxt = S_RUN;
                else if (step_req) state_nxt = S_STEP;
            end
            S_RUN: begin
                if (!run_sw)              state_nxt = S_PAUSE;
                else if (tick && bp_hit)  state_nxt = S_BREAK;
                else                      cpu_ce    = tick;
            end
            S_STEP: begin
                if (tick) begin
                    cpu_ce    = 1'b1;
                    state_nxt = S_PAUSE;
                end
            end
            default: begin
                if (step_req)     state_nxt = S_STEP;
                else if (!run_sw) state_nxt = S_PAUSE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_PAUSE;
            step_count <= '0;
        end else begin
            state <= state_nxt;
            if (cpu_ce) step_count <= step_count + 16'd1;
        end
    end

    assign halted = (state != S_RUN);

    // An out-of-range ch_sel matches no channel and leaves the LEDs dark
    always_comb begin
        led_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == SEL_W'(k)) begin
                led_nxt = half_sel ? ch_data[k*DATA_W + LED_W +: LED_W]
                                   : ch_data[k*DATA_W +: LED_W];
            end
        end
    end

    // Stage p1: registered display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= '0;
        else       led <= led_nxt;
    end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: reset, free-run divider, debounce,
// breakpoint, LED mux and reset during a pending step.
module tb_mips_debug_ctrl;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int LED_W  = 16;
    localparam int DIV_W  = 26;
    localparam int DEB    = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     run_sw;
    logic                     step_btn;
    logic [4:0]               div_sel;
    logic                     bp_en;
    logic [DATA_W-1:0]        bp_addr;
    logic [DATA_W-1:0]        pc_in;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [1:0]               ch_sel;
    logic                     half_sel;
    logic                     cpu_ce;
    logic                     halted;
    logic [1:0]               state;
    logic [15:0]              step_count;
    logic [LED_W-1:0]         led;

    int checks   = 0;
    int failures = 0;

    mips_debug_ctrl #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .LED_W(LED_W),
        .DIV_W(DIV_W), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
        .div_sel(div_sel), .bp_en(bp_en), .bp_addr(bp_addr), .pc_in(pc_in),
        .ch_data(ch_data), .ch_sel(ch_sel), .half_sel(half_sel),
        .cpu_ce(cpu_ce), .halted(halted), .state(state),
        .step_count(step_count), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ce_cnt;
        int last_idx;
        int sc0;
        bit found;
        bit bad;

        reset    = 1'b1;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        div_sel  = 5'd3;
        bp_en    = 1'b0;
        bp_addr  = 32'h40;
        pc_in    = 32'h0;
        ch_data  = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h5555_AAAA, 32'h1234_5678};
        ch_sel   = 2'd0;
        half_sel = 1'b0;

        // Reset state
        repeat (3) step_clk();
        check("rst_state", state, 2'b01);
        check("rst_halted", halted, 1'b1);
        check("rst_cpu_ce", cpu_ce, 1'b0);
        check("rst_led", led, 16'h0);
        check("rst_step_count", step_count, 16'h0);
        reset = 1'b0;

        ce_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cpu_ce) ce_cnt++;
            step_clk();
        end
        check("pause_no_ce", ce_cnt, 0);
        check("pause_state", state, 2'b01);

        // Free run, tick every 8 cycles
        run_sw = 1'b1;
        step_clk();
        check("run_state", state, 2'b00);
        check("run_halted", halted, 1'b0);
        ce_cnt   = 0;
        last_idx = -1;
        for (int i = 0; i < 80; i++) begin
            if (cpu_ce) begin
                ce_cnt++;
                if (last_idx >= 0) check("run_ce_gap", i - last_idx, 8);
                last_idx = i;
            end
            step_clk();
        end
        check("run_ce_count", ce_cnt, 10);
        check("run_step_count", step_count, 16'd10);
        run_sw = 1'b0;
        step_clk();
        check("run_to_pause", state, 2'b01);

        // Bouncing button never reaches debounce threshold
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) step_btn = ~step_btn;
            if (cpu_ce || state != 2'b01) bad = 1'b1;
            step_clk();
        end
        check("bounce_no_step", bad, 1'b0);
        check("bounce_step_count", step_count, 16'd10);

        // Stable press gives exactly one step
        ce_cnt = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) step_btn = 1'b0;
            if (cpu_ce) ce_cnt++;
            step_clk();
        end
        check("step_one_ce", ce_cnt, 1);
        check("step_count_inc", step_count, 16'd11);
        check("step_back_pause", state, 2'b01);

        // Breakpoint at 0x40
        bp_en  = 1'b1;
        pc_in  = 32'h3C;
        run_sw = 1'b1;
        step_clk();
        check("bp_run_state", state, 2'b00);
        sc0   = int'(step_count);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cpu_ce) found = 1'b1;
            step_clk();
        end
        check("bp_first_ce_seen", found, 1'b1);
        pc_in  = 32'h40;
        found  = 1'b0;
        ce_cnt = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (state == 2'b11) found = 1'b1;
            else begin
                if (cpu_ce) ce_cnt++;
                step_clk();
            end
        end
        check("bp_reached", found, 1'b1);
        check("bp_no_ce_on_match", ce_cnt, 0);
        check("bp_step_count", step_count, 16'(sc0 + 1));
        check("bp_halted", halted, 1'b1);

        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_ce || state != 2'b11) bad = 1'b1;
            step_clk();
        end
        check("bp_run_sw_no_resume", bad, 1'b0);

        // Step past the breakpoint with run_sw still high
        ce_cnt   = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) step_btn = 1'b0;
            if (cpu_ce) begin
                ce_cnt++;
                step_clk();
                check("bp_step_to_pause", state, 2'b01);
                run_sw = 1'b0;
                pc_in  = 32'h44;
            end else begin
                step_clk();
            end
        end
        check("bp_step_one_ce", ce_cnt, 1);
        check("bp_step_end_state", state, 2'b01);
        check("bp_step_count_after", step_count, 16'(sc0 + 2));
        bp_en = 1'b0;

        // LED mux
        ch_sel = 2'd2; half_sel = 1'b0;
        step_clk();
        check("led_ch2_lo", led, 16'hBEEF);
        half_sel = 1'b1;
        step_clk();
        check("led_ch2_hi", led, 16'hDEAD);
        ch_sel = 2'd0;
        step_clk();
        check("led_ch0_hi", led, 16'h1234);
        ch_sel = 2'd3; half_sel = 1'b0;
        step_clk();
        check("led_ch3_lo", led, 16'hF00D);

        // Reset while a step waits on a very slow (clamped) tick
        div_sel  = 5'd31;
        step_btn = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (state == 2'b10) found = 1'b1;
            else step_clk();
        end
        check("rst_step_entered", found, 1'b1);
        check("rst_step_no_ce", cpu_ce, 1'b0);
        step_btn = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_mid_step_state", state, 2'b01);
        check("rst_mid_step_ce", cpu_ce, 1'b0);
        check("rst_mid_step_led", led, 16'h0);
        step_clk();
        step_clk();
        reset   = 1'b0;
        div_sel = 5'd0;
        ce_cnt  = 0;
        for (int i = 0; i < 50; i++) begin
            if (cpu_ce) ce_cnt++;
            step_clk();
        end
        check("rst_no_late_pulse", ce_cnt, 0);
        check("rst_final_state", state, 2'b01);
        check("rst_final_count", step_count, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
